// File: rtl/store_buffer.sv
// store_buffer: queues stores so they retire in one cycle and drains them into the single memory port whenever no load uses it.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iReqValid,
    input  logic        iReqWrite,
    input  logic        iReqRead,
    input  logic [31:0] iReqAddress,
    input  logic [31:0] iReqWriteData,
    input  logic [2:0]  iReqFunct3,
    output logic        oReqReady,
    output logic [31:0] oLoadData,
    output logic        oLoadValid,
    output logic        oEmpty,
    output logic [31:0] oMemAddress,
    output logic [31:0] oMemWriteData,
    output logic [2:0]  oMemFunct3,
    output logic        oMemWrite,
    output logic        oMemRead,
    input  logic [31:0] iMemReadData
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] entAddr [DEPTH];
    logic [31:0] entData [DEPTH];
    logic [2:0]  entFunct3 [DEPTH];
    logic [AW:0] head, tail, count;
    logic        full, isStore, isLoad, badStore, conflict, loadGrant, drain, push;
    logic [32:0] loadLo, loadHi, entLo, entHi;

    function automatic logic [32:0] accessSize(input logic [2:0] f);
        return f[1] ? 33'd4 : f[0] ? 33'd2 : 33'd1;
    endfunction

    assign full      = count == (AW+1)'(DEPTH);
    assign oEmpty    = count == '0;
    // Requests are masked during reset so every output reads zero.
    assign isStore   = iRstN & iReqValid & iReqWrite;
    assign isLoad    = iRstN & iReqValid & iReqRead & ~iReqWrite;
    assign badStore  = iReqFunct3[2] | (iReqFunct3[1] & iReqFunct3[0]);
    assign loadLo    = {1'b0, iReqAddress};
    assign loadHi    = loadLo + accessSize(iReqFunct3);

    always_comb begin
        conflict = 1'b0;
        entLo    = '0;
        entHi    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entLo = {1'b0, entAddr[i]};
            entHi = entLo + accessSize(entFunct3[i]);
            if (({1'b0, AW'(i) - head[AW-1:0]} < count) && loadLo < entHi && entLo < loadHi)
                conflict = 1'b1;
        end
    end

    assign loadGrant = isLoad & ~conflict & ~full;
    assign drain     = ~oEmpty & ~loadGrant;
    assign push      = isStore & ~full & ~badStore;

    assign oReqReady     = isStore ? (badStore | ~full) : loadGrant;
    assign oLoadValid    = loadGrant;
    assign oLoadData     = loadGrant ? iMemReadData : '0;
    assign oMemRead      = loadGrant;
    assign oMemWrite     = drain;
    assign oMemAddress   = loadGrant ? iReqAddress : drain ? entAddr[head[AW-1:0]] : '0;
    assign oMemWriteData = loadGrant ? iReqWriteData : drain ? entData[head[AW-1:0]] : '0;
    assign oMemFunct3    = loadGrant ? iReqFunct3 : drain ? entFunct3[head[AW-1:0]] : '0;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(drain);
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            entAddr[tail[AW-1:0]]   <= iReqAddress;
            entData[tail[AW-1:0]]   <= iReqWriteData;
            entFunct3[tail[AW-1:0]] <= iReqFunct3;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized check of store_buffer against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    logic        iReqValid = 1'b0, iReqWrite = 1'b0, iReqRead = 1'b0;
    logic [31:0] iReqAddress = '0, iReqWriteData = '0, iMemReadData = '0;
    logic [2:0]  iReqFunct3 = '0;
    logic        oReqReady, oLoadValid, oEmpty, oMemWrite, oMemRead;
    logic [31:0] oLoadData, oMemAddress, oMemWriteData;
    logic [2:0]  oMemFunct3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } entry_t;

    entry_t q[$];
    int nChecks = 0;
    int nFails = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iReqValid(iReqValid), .iReqWrite(iReqWrite), .iReqRead(iReqRead),
        .iReqAddress(iReqAddress), .iReqWriteData(iReqWriteData), .iReqFunct3(iReqFunct3),
        .oReqReady(oReqReady), .oLoadData(oLoadData), .oLoadValid(oLoadValid), .oEmpty(oEmpty),
        .oMemAddress(oMemAddress), .oMemWriteData(oMemWriteData), .oMemFunct3(oMemFunct3),
        .oMemWrite(oMemWrite), .oMemRead(oMemRead), .iMemReadData(iMemReadData)
    );

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sizeOf(input logic [2:0] f);
        return f[1] ? 4 : f[0] ? 2 : 1;
    endfunction

    task automatic checkAllZero(input string tag);
        checkVal({tag, " ready"}, oReqReady, 0);
        checkVal({tag, " loadValid"}, oLoadValid, 0);
        checkVal({tag, " loadData"}, oLoadData, 0);
        checkVal({tag, " empty"}, oEmpty, 1);
        checkVal({tag, " memWrite"}, oMemWrite, 0);
        checkVal({tag, " memRead"}, oMemRead, 0);
        checkVal({tag, " memAddr"}, oMemAddress, 0);
        checkVal({tag, " memData"}, oMemWriteData, 0);
        checkVal({tag, " memF3"}, oMemFunct3, 0);
    endtask

    // Reset asserted with a store request still presented; everything must read zero.
    task automatic doReset();
        @(negedge iClk);
        iRstN = 1'b0;
        iReqValid = 1'b1; iReqWrite = 1'b1; iReqRead = 1'b0;
        iReqAddress = 32'h500; iReqWriteData = 32'h12345678; iReqFunct3 = 3'b010;
        #1 checkAllZero("rst");
        q.delete();
        @(posedge iClk);
        #1 checkAllZero("rstHeld");
        iRstN = 1'b1;
        iReqValid = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic   isStore, isLoad, full, bad, conflict, grant, drain, push;
        logic [31:0] md, expAddr, expData;
        logic [2:0]  expF3;
        longint la, ea;
        @(negedge iClk);
        md = $urandom;
        iReqValid = v; iReqWrite = w; iReqRead = r;
        iReqAddress = a; iReqWriteData = d; iReqFunct3 = f; iMemReadData = md;
        isStore = v && w;
        isLoad  = v && r && !w;
        full    = q.size() == DEPTH;
        bad     = !(f == 3'd0 || f == 3'd1 || f == 3'd2);
        la = a;
        conflict = 1'b0;
        foreach (q[i]) begin
            ea = q[i].a;
            if (la < ea + sizeOf(q[i].f) && ea < la + sizeOf(f)) conflict = 1'b1;
        end
        grant = isLoad && !conflict && !full;
        drain = q.size() > 0 && !grant;
        push  = isStore && !full && !bad;
        expAddr = grant ? a : drain ? q[0].a : 32'h0;
        expData = grant ? d : drain ? q[0].d : 32'h0;
        expF3   = grant ? f : drain ? q[0].f : 3'h0;
        #1;
        checkVal("ready", oReqReady, isStore ? (bad || !full) : grant);
        checkVal("loadValid", oLoadValid, grant);
        checkVal("loadData", oLoadData, grant ? md : 32'h0);
        checkVal("empty", oEmpty, q.size() == 0);
        checkVal("memRead", oMemRead, grant);
        checkVal("memWrite", oMemWrite, drain);
        checkVal("memAddr", oMemAddress, expAddr);
        checkVal("memData", oMemWriteData, expData);
        checkVal("memF3", oMemFunct3, expF3);
        @(posedge iClk);
        if (drain) void'(q.pop_front());
        if (push) q.push_back('{a, d, f});
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int kind;
        #1 checkAllZero("init");
        doReset();
        // SW then idle: one-cycle queue, drained next cycle
        cycle(1, 1, 0, 32'h100, 32'hDEADBEEF, 3'b010);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // SB 0x200 then LW 0x1FE: stalled once, then granted
        cycle(1, 1, 0, 32'h200, 32'h7F, 3'b000);
        cycle(1, 0, 1, 32'h1FE, 0, 3'b010);
        cycle(1, 0, 1, 32'h1FE, 0, 3'b010);
        // SW 0x300 then LW 0x304: granted immediately, drain deferred
        cycle(1, 1, 0, 32'h300, 32'hCAFEF00D, 3'b010);
        cycle(1, 0, 1, 32'h304, 0, 3'b010);
        cycle(1, 0, 1, 32'h304, 0, 3'b010);
        cycle(0, 0, 0, 0, 0, 0);
        // unsupported store size is dropped
        cycle(1, 1, 0, 32'h380, 32'h11111111, 3'b011);
        cycle(0, 0, 0, 0, 0, 0);
        // top-of-address-space ranges must not wrap to 0
        cycle(1, 1, 0, 32'hFFFFFFFF, 32'hABCD, 3'b001);
        cycle(1, 0, 1, 32'h0, 0, 3'b000);
        cycle(1, 0, 1, 32'hFFFFFFFC, 0, 3'b010);
        cycle(1, 0, 1, 32'hFFFFFFFC, 0, 3'b010);
        // reset with a store queued loses it
        cycle(1, 1, 0, 32'h600, 32'h55AA55AA, 3'b010);
        doReset();
        cycle(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) doReset();
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? $urandom :
                ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7) :
                32'h400 + $urandom_range(0, 15);
            if (kind < 4) begin
                f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                cycle(1, 1, $urandom_range(0, 1), a, $urandom, f);
            end else if (kind < 8) begin
                cycle(1, 0, 1, a, $urandom, 3'($urandom_range(0, 7)));
            end else begin
                cycle(kind == 8, 0, 0, a, $urandom, 3'($urandom_range(0, 7)));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
